// File: rtl/bmd_compl_tracker.sv
// Non-posted completion tracker.
// Queues request descriptors from the RX engine and hands the head entry to
// the TX completion engine. A small power FSM drains the queue before it
// acknowledges a power-state change.
`timescale 1ns/1ps

module bmd_compl_tracker #(
    parameter int TCQ    = 1,
    parameter int DEPTH  = 4,
    parameter int DESC_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_np_valid,
    input  logic [DESC_W-1:0]          rx_np_desc,
    output logic                       rx_np_ready,
    output logic                       req_compl,
    output logic [DESC_W-1:0]          req_desc,
    input  logic                       tx_compl_done,
    input  logic                       cfg_power_state_change_interrupt,
    output logic                       cfg_power_state_change_ack,
    output logic                       compl_pending,
    output logic [$clog2(DEPTH):0]     outstanding,
    output logic                       err_unexp_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    // The register model is zero-delay; TCQ is kept so the parameter list
    // matches the rest of the BMD family. Reject illegal parameter values.
    if ((DEPTH < 32'sd2) || (DEPTH > 32'sd16) ||
        ((DEPTH & (DEPTH - 32'sd1)) != 32'sd0) || (TCQ < 32'sd0)) begin : g_bad_param
        $error("bmd_compl_tracker: DEPTH must be a power of 2 in 2..16 and TCQ >= 0");
    end

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_ACK      = 2'd2,
        ST_WAIT_REL = 2'd3
    } pwr_state_t;

    pwr_state_t          state_r;
    logic [AW-1:0]       wr_ptr_r;
    logic [AW-1:0]       rd_ptr_r;
    logic [CW-1:0]       count_r;
    logic                err_r;
    logic [DESC_W-1:0]   mem_r [DEPTH];

    logic                ready_s;
    logic                req_s;
    logic                push_s;
    logic                pop_s;
    logic                unexp_s;

    // Handshake decode; everything here depends on registered state only.
    always_comb begin
        ready_s = 1'b0;
        req_s   = 1'b0;
        if ((count_r < DEPTH_C) && (state_r == ST_RUN)) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
        if ((count_r != CNT_ZERO) && (state_r != ST_ACK)) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
        push_s  = rx_np_valid & ready_s;
        pop_s   = tx_compl_done & req_s;
        unexp_s = tx_compl_done & ~req_s;
    end

    // Descriptor storage write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= rx_np_desc;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky flag for a done pulse that arrives with nothing requested.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (unexp_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    // Power FSM: drain the queue, ack once, then wait for the request to drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (cfg_power_state_change_interrupt) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (!cfg_power_state_change_interrupt) begin
                        state_r <= ST_RUN;
                    end else if (count_r == CNT_ZERO) begin
                        state_r <= ST_ACK;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_ACK: begin
                    state_r <= ST_WAIT_REL;
                end
                ST_WAIT_REL: begin
                    if (!cfg_power_state_change_interrupt) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_WAIT_REL;
                    end
                end
                default: begin
                    state_r <= ST_RUN;
                end
            endcase
        end
    end

    // Output decode of the registered state.
    always_comb begin
        rx_np_ready                = ready_s;
        req_compl                  = req_s;
        req_desc                   = mem_r[rd_ptr_r];
        compl_pending              = (count_r != CNT_ZERO);
        outstanding                = count_r;
        err_unexp_done             = err_r;
        cfg_power_state_change_ack = (state_r == ST_ACK);
    end

endmodule
